// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control front-end that turns a dual-port register-file memory with a
// one-cycle registered read port into a first-word-fall-through FIFO.
//
// The FIFO is split into two parts:
//   - words still held in the memory, tracked by mem_cnt_q
//   - the head word, already read out and presented on mem_rd_data, tracked by out_valid_q
// Only the memory part counts toward full. This lets the head register hold one extra word,
// so the total capacity is MAX_ADDR + 1.
module fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned MAX_ADDR   = 8,
    parameter int unsigned ADDRSIZE   = $clog2(MAX_ADDR)
) (
    input  logic                  clk,
    input  logic                  reset,

    // Upstream write interface
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,

    // Downstream read interface
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,

    // Memory side
    output logic                  mem_rd_en,
    output logic [ADDRSIZE-1:0]   mem_rd_addr,
    output logic                  mem_wr_en,
    output logic [ADDRSIZE-1:0]   mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,

    // Occupancy
    output logic [ADDRSIZE:0]     count
);

    localparam int unsigned CntW = ADDRSIZE + 1;

    localparam logic [ADDRSIZE-1:0] LastAddr = ADDRSIZE'(MAX_ADDR - 1);
    localparam logic [CntW-1:0]     FullCnt  = CntW'(MAX_ADDR);
    localparam logic [CntW-1:0]     OneCnt   = CntW'(1);

    logic [ADDRSIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRSIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]     mem_cnt_q, mem_cnt_d;
    logic                out_valid_q, out_valid_d;

    logic full;
    logic wr_fire;
    logic rd_fire;

    // Handshake decode from registered state only; the head register is excluded from full.
    always_comb begin
        full    = (mem_cnt_q == FullCnt);
        wr_fire = in_valid && !full;
        // Issue a read when memory holds a word and the head slot is free or being vacated.
        rd_fire = (mem_cnt_q != '0) && (!out_valid_q || out_ready);
    end

    // Next-state for pointers, memory occupancy and the head-valid flag.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_cnt_d   = mem_cnt_q;
        out_valid_d = out_valid_q;

        // Explicit wrap compare so MAX_ADDR need not be a power of two.
        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({wr_fire, rd_fire})
            2'b10:   mem_cnt_d = mem_cnt_q + OneCnt;
            2'b01:   mem_cnt_d = mem_cnt_q - OneCnt;
            default: mem_cnt_d = mem_cnt_q;
        endcase

        // A fresh read refills the head; otherwise a pop empties it.
        if (rd_fire) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Port mapping: the memory holds rd_data while rd_en is low, so out_data stays stable.
    always_comb begin
        in_ready    = !full;
        out_valid   = out_valid_q;
        out_data    = mem_rd_data;
        mem_rd_en   = rd_fire;
        mem_rd_addr = rd_ptr_q;
        mem_wr_en   = wr_fire;
        mem_wr_addr = wr_ptr_q;
        mem_wr_data = in_data;
        count       = mem_cnt_q + CntW'(out_valid_q);
    end

    // Occupancy and pointers stay in range, including non-power-of-two depths.
    a_cnt_range: assert property (@(posedge clk) disable iff (reset)
        mem_cnt_q <= FullCnt);
    a_wr_ptr_range: assert property (@(posedge clk) disable iff (reset)
        wr_ptr_q <= LastAddr);
    a_rd_ptr_range: assert property (@(posedge clk) disable iff (reset)
        rd_ptr_q <= LastAddr);

    // A read and a write in the same cycle never target the same slot.
    a_no_same_addr: assert property (@(posedge clk) disable iff (reset)
        (mem_wr_en && mem_rd_en) |-> (mem_wr_addr != mem_rd_addr));

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed bench for fifo_ctrl paired with a behavioural register-file memory.
// A queue-based FIFO model predicts every output on every cycle. Literal checks pin the
// model against hand-computed values.
module tb_fifo_ctrl;

    localparam int unsigned DW = 3;
    localparam int unsigned MA = 4;
    localparam int unsigned AW = $clog2(MA);

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;
    logic [AW:0]   count;

    fifo_ctrl #(
        .DATA_WIDTH (DW),
        .MAX_ADDR   (MA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .count       (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Companion memory: registered read, holds rd_data while idle, clears on reset.
    logic [DW-1:0] mem [MA];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(MA); i++) mem[i] <= '0;
            mem_rd_data <= '0;
        end else begin
            if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
            if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        end
    end

    // ---------------- checking infrastructure ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_q:  words in memory, in arrival order.
    // m_ov/m_od: the head word currently presented downstream.
    logic [DW-1:0] m_q[$];
    bit            m_ov;
    logic [DW-1:0] m_od;
    int            wr_total;
    int            rd_total;
    bit            live = 0;

    function automatic bit m_issue();
        return (m_q.size() != 0) && (!m_ov || out_ready);
    endfunction

    function automatic bit m_accept();
        return in_valid && (m_q.size() < int'(MA));
    endfunction

    task automatic model_step();
        bit iss;
        bit acc;
        if (reset) begin
            m_q.delete();
            m_ov     = 0;
            wr_total = 0;
            rd_total = 0;
            live     = 1;
        end else begin
            iss = m_issue();
            acc = m_accept();
            if (iss) begin
                m_od = m_q.pop_front();
                m_ov = 1;
                rd_total++;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (acc) begin
                m_q.push_back(in_data);
                wr_total++;
            end
        end
    endtask

    // Words actually handed downstream, compared later against literal lists.
    logic [DW-1:0] popped[$];

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (live) begin
            check("in_ready", 32'(in_ready), 32'(m_q.size() < int'(MA)));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            check("count", 32'(count), 32'(m_q.size() + int'(m_ov)));
            check("mem_wr_en", 32'(mem_wr_en), 32'(m_accept()));
            check("mem_rd_en", 32'(mem_rd_en), 32'(m_issue()));
            if (m_accept()) begin
                check("mem_wr_addr", 32'(mem_wr_addr), 32'(wr_total % int'(MA)));
                check("mem_wr_data", 32'(mem_wr_data), 32'(in_data));
            end
            if (m_issue()) begin
                check("mem_rd_addr", 32'(mem_rd_addr), 32'(rd_total % int'(MA)));
            end
            if (m_ov) check("out_data", 32'(out_data), 32'(m_od));
            if (out_valid && out_ready) popped.push_back(out_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    logic [DW-1:0] exp_drain [5];
    logic [DW-1:0] burst     [6];
    bit            got;

    initial begin
        exp_drain = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
        burst     = '{3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd6};
        drive(0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset then idle.
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_wr_en", 32'(mem_wr_en), 0);
        check("rst_rd_en", 32'(mem_rd_en), 0);
        tick();

        // Single word with stalled consumer: visible two edges after acceptance.
        drive(1, 3'd5, 0);
        @(negedge clk);
        check("w5_wr_addr", 32'(mem_wr_addr), 0);
        check("w5_wr_en", 32'(mem_wr_en), 1);
        tick();
        drive(0, 0, 0);
        @(negedge clk);
        check("w5_lat1_out_valid", 32'(out_valid), 0);
        check("w5_lat1_rd_en", 32'(mem_rd_en), 1);
        check("w5_lat1_count", 32'(count), 1);
        tick();
        @(negedge clk);
        check("w5_out_valid", 32'(out_valid), 1);
        check("w5_out_data", 32'(out_data), 5);
        check("w5_count", 32'(count), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("w5_hold_data", 32'(out_data), 5);
            check("w5_hold_valid", 32'(out_valid), 1);
        end
        tick();

        // Fill to capacity: five accepted, sixth rejected.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, burst[i], 0);
            if (i == 5) begin
                @(negedge clk);
                check("full_in_ready", 32'(in_ready), 0);
                check("full_wr_en", 32'(mem_wr_en), 0);
            end
            tick();
        end
        drive(0, 0, 0);
        @(negedge clk);
        check("full_count", 32'(count), 5);
        check("full_in_ready_after", 32'(in_ready), 0);
        tick();

        // Drain: the pop in the first cycle does not raise in_ready until the next cycle.
        popped.delete();
        drive(0, 0, 1);
        @(negedge clk);
        check("drain_in_ready_first", 32'(in_ready), 0);
        tick();
        @(negedge clk);
        check("drain_in_ready_next", 32'(in_ready), 1);
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        check("drain_out_valid", 32'(out_valid), 0);
        check("drain_count", 32'(count), 0);
        check("drain_len", 32'(popped.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < popped.size()) check("drain_word", 32'(popped[i]), 32'(exp_drain[i]));
        end
        tick();

        // Streaming 0..7 with both sides ready.
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1, DW'(i), 1);
            @(negedge clk);
            check("stream_in_ready", 32'(in_ready), 1);
            check("stream_count_le2", 32'(count <= 2), 1);
            tick();
        end
        drive(0, 0, 1);
        for (int i = 0; i < 4; i++) tick();
        check("stream_len", 32'(popped.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < popped.size()) check("stream_word", 32'(popped[i]), 32'(i));
        end

        // Reset with three words held.
        for (int i = 0; i < 3; i++) begin
            drive(1, DW'(i + 1), 0);
            tick();
        end
        drive(0, 0, 0);
        @(negedge clk);
        check("prerst_count", 32'(count), 3);
        do_reset();
        @(negedge clk);
        check("postrst_count", 32'(count), 0);
        check("postrst_out_valid", 32'(out_valid), 0);
        check("postrst_in_ready", 32'(in_ready), 1);
        popped.delete();
        drive(1, 3'd6, 1);
        tick();
        drive(0, 0, 1);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick();
            if (popped.size() != 0) got = 1;
        end
        check("postrst_first_seen", 32'(got), 1);
        if (got) check("postrst_first_word", 32'(popped[0]), 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control front-end that turns the dual-port register-file `memory` block into a first-word-fall-through FIFO.
- Upstream side: valid/ready write interface. Downstream side: valid/ready read interface.
- Drives the memory's rd_en/rd_addr/wr_en/wr_addr/wr_data and consumes its registered rd_data (1-cycle read latency).
- Instantiated side by side with `memory`, sharing the same clk/reset and parameters.

Parameters:
- DATA_WIDTH, 4, word width; must match the memory instance.
- MAX_ADDR, 8, memory depth in words (≥2; need not be a power of 2).
- ADDRSIZE, $clog2(MAX_ADDR), pointer width.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_data  input  DATA_WIDTH  upstream word.
- in_ready  output  1  = !full; a write happens when in_valid && in_ready.
- out_valid  output  1  out_data is a valid head word.
- out_data  output  DATA_WIDTH  head word; wired directly from mem_rd_data.
- out_ready  input  1  consumer takes the head when out_valid && out_ready.
- mem_rd_en  output  1  to memory rd_en.
- mem_rd_addr  output  ADDRSIZE  to memory rd_addr (= rd_ptr).
- mem_wr_en  output  1  to memory wr_en (= in_valid && in_ready).
- mem_wr_addr  output  ADDRSIZE  to memory wr_addr (= wr_ptr).
- mem_wr_data  output  DATA_WIDTH  to memory wr_data (= in_data).
- mem_rd_data  input  DATA_WIDTH  from memory rd_data.
- count  output  ADDRSIZE+1  total words held (= mem_cnt + out_valid).

Behaviour:
- State registers:
  - wr_ptr, rd_ptr: ADDRSIZE bits each.
  - mem_cnt: ADDRSIZE+1 bits; words in memory not yet read out.
  - out_valid: 1 bit.
- Reset (sync): wr_ptr=0, rd_ptr=0, mem_cnt=0, out_valid=0. Consequently in_ready=1, count=0, mem_wr_en=0, mem_rd_en=0.
- full = (mem_cnt == MAX_ADDR). in_ready = !full. The output register does not count toward full.
- Write: wr_fire = in_valid && !full. On wr_fire, mem_wr_en=1 and wr_ptr advances.
- Pointer wrap: a pointer at MAX_ADDR-1 goes to 0, otherwise +1. Explicit compare; no reliance on power-of-2 overflow.
- Read issue (combinational): rd_fire = (mem_cnt != 0) && (!out_valid || out_ready). mem_rd_en = rd_fire. On rd_fire, rd_ptr advances.
- out_valid next = rd_fire ? 1 : (out_ready ? 0 : out_valid).
  - out_data is valid the cycle after rd_fire.
  - The memory holds rd_data while rd_en=0, so the head word stays stable under backpressure.
- mem_cnt next = mem_cnt + wr_fire − rd_fire. Simultaneous write and read leave it unchanged.
- Latency:
  - Word accepted at edge N → may be read-issued in cycle N+1 (mem_cnt registered) → out_valid=1 after edge N+2.
  - Empty-FIFO fall-through is therefore 2 cycles.
- Same-address hazard: impossible by construction. Reads are issued only when mem_cnt≠0 from registered state, so rd_ptr never equals the wr_ptr being written in the same cycle.
- Full plus consumer pop: in_ready stays 0 that cycle (registered full). It rises the next cycle once mem_cnt decrements.
- Streaming: with out_ready held 1 and data present, one word per cycle in and out.
- Reset mid-operation: all contents are discarded and out_valid drops after the reset edge. The memory clears itself in parallel.
- No underflow or overflow is possible. Writes while full and pops while !out_valid are ignored with no state change.

Test Plan (DATA_WIDTH=3, MAX_ADDR=4):
- Reset then idle → in_ready=1, out_valid=0, count=0, mem_wr_en=mem_rd_en=0.
- Write 5 with out_ready=0 → mem_wr_addr=0; out_valid=1 with out_data=5 two edges later; count=1; out_data holds 5 over 3 further stalled cycles.
- Write 5,4,3,2,1 back-to-back with out_ready=0 → first 5 words accepted (4 in memory + 1 in output register); in_ready=0 afterwards; sixth word rejected; count=5.
- Drain the previous state with out_ready=1 → out_data sequence 5,4,3,2,1 on consecutive cycles; wr/rd pointers wrap through 3→0; then out_valid=0, count=0.
- Continuous stream of 0..7 with in_valid=out_ready=1 → output 0..7 in order, one per cycle after 2-cycle latency; count stays ≤2; in_ready never drops.
- Assert reset while count=3 → next cycle count=0, out_valid=0, in_ready=1; a subsequent write of 6 emerges as the first word.
